match_sequencer: RTL and testbench

Round and match controller for the tug-of-war game. It gates when player moves are accepted, runs a countdown before each round, and pulses the round reset to the light chain after each point. It tallies round wins to a best-of target and declares the match winner. It sits between the victory detectors (its inputs) and the user-input and light modules (its outputs), all on the divided game clock.

---
 rtl/match_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_match_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// match_sequencer: round and match controller for the tug-of-war game.
//
// Gates when player moves are accepted, runs a per-round countdown,
// pulses the round reset to the light chain and tallies round wins up to a
// best-of target.
//
// Ports:
//   clk          game clock (divided); the only clock in the block
//   reset        synchronous, active-high; forces IDLE and clears every output
//   start        single-cycle pulse; starts a match from IDLE or restarts from OVER
//   humanWin     round won by the human (victory detector)
//   compWin      round won by the computer (victory detector)
//   playEnable   high only in PLAY; gates the move outputs
//   resetRound   one-cycle pulse on every COUNTDOWN entry; recentres the lights
//   phase        IDLE=0, COUNTDOWN=1, PLAY=2, HOLD=3, OVER=4
//   digit        current countdown digit, 0 outside COUNTDOWN
//   humanScore   human round wins
//   compScore    computer round wins
//   roundWinner  00 none, 01 human, 10 computer, 11 tie (HOLD/OVER only)
//   matchOver    high in OVER
//   matchWinner  0 human, 1 computer; valid while matchOver is high
module match_sequencer #(
    parameter int unsigned WIN_TARGET  = 3,
    parameter int unsigned COUNT_FROM  = 3,
    parameter int unsigned COUNT_TICKS = 4,
    parameter int unsigned HOLD_TICKS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       humanWin,
    input  logic       compWin,
    output logic       playEnable,
    output logic       resetRound,
    output logic [2:0] phase,
    output logic [2:0] digit,
    output logic [2:0] humanScore,
    output logic [2:0] compScore,
    output logic [1:0] roundWinner,
    output logic       matchOver,
    output logic       matchWinner
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCountdown = 3'd1,
        StPlay      = 3'd2,
        StHold      = 3'd3,
        StOver      = 3'd4
    } phase_e;

    localparam logic [2:0] WinTarget = 3'(WIN_TARGET);
    localparam logic [2:0] CountFrom = 3'(COUNT_FROM);
    // Terminal timer values; ranges go up to 256 so an 8-bit timer is enough.
    localparam logic [7:0] CountLast = 8'(COUNT_TICKS - 1);
    localparam logic [7:0] HoldLast  = 8'(HOLD_TICKS - 1);

    phase_e     phase_q, phase_d;
    logic [2:0] digit_q, digit_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] human_score_q, human_score_d;
    logic [2:0] comp_score_q, comp_score_d;
    logic [1:0] round_winner_q, round_winner_d;
    logic       match_winner_q, match_winner_d;
    logic       match_over_q, match_over_d;
    logic       play_enable_q, play_enable_d;
    logic       reset_round_q, reset_round_d;

    logic [2:0] human_inc;
    logic [2:0] comp_inc;

    assign human_inc = human_score_q + 3'd1;
    assign comp_inc  = comp_score_q + 3'd1;

    always_comb begin
        phase_d        = phase_q;
        digit_d        = digit_q;
        timer_d        = timer_q;
        human_score_d  = human_score_q;
        comp_score_d   = comp_score_q;
        round_winner_d = round_winner_q;
        match_winner_d = match_winner_q;
        reset_round_d  = 1'b0;

        unique case (phase_q)
            StIdle: begin
                if (start) begin
                    phase_d       = StCountdown;
                    digit_d       = CountFrom;
                    timer_d       = 8'd0;
                    reset_round_d = 1'b1;
                end
            end
            StCountdown: begin
                if (timer_q == CountLast) begin
                    timer_d = 8'd0;
                    if (digit_q > 3'd1) begin
                        digit_d = digit_q - 3'd1;
                    end else begin
                        digit_d = 3'd0;
                        phase_d = StPlay;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StPlay: begin
                // Leaving PLAY on the first win cycle is what makes a long
                // win pulse credit only once.
                unique case ({humanWin, compWin})
                    2'b11: begin
                        round_winner_d = 2'b11;
                        phase_d        = StHold;
                        timer_d        = 8'd0;
                    end
                    2'b10: begin
                        human_score_d  = human_inc;
                        round_winner_d = 2'b01;
                        timer_d        = 8'd0;
                        if (human_inc == WinTarget) begin
                            phase_d        = StOver;
                            match_winner_d = 1'b0;
                        end else begin
                            phase_d = StHold;
                        end
                    end
                    2'b01: begin
                        comp_score_d   = comp_inc;
                        round_winner_d = 2'b10;
                        timer_d        = 8'd0;
                        if (comp_inc == WinTarget) begin
                            phase_d        = StOver;
                            match_winner_d = 1'b1;
                        end else begin
                            phase_d = StHold;
                        end
                    end
                    default: ;
                endcase
            end
            StHold: begin
                if (timer_q == HoldLast) begin
                    phase_d        = StCountdown;
                    digit_d        = CountFrom;
                    timer_d        = 8'd0;
                    reset_round_d  = 1'b1;
                    round_winner_d = 2'b00;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StOver: begin
                if (start) begin
                    phase_d        = StCountdown;
                    digit_d        = CountFrom;
                    timer_d        = 8'd0;
                    reset_round_d  = 1'b1;
                    human_score_d  = 3'd0;
                    comp_score_d   = 3'd0;
                    round_winner_d = 2'b00;
                    match_winner_d = 1'b0;
                end
            end
            default: begin
                phase_d = StIdle;
            end
        endcase

        // Decoded from the next phase so these flags are registered with it.
        play_enable_d = (phase_d == StPlay);
        match_over_d  = (phase_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= StIdle;
            digit_q        <= 3'd0;
            timer_q        <= 8'd0;
            human_score_q  <= 3'd0;
            comp_score_q   <= 3'd0;
            round_winner_q <= 2'b00;
            match_winner_q <= 1'b0;
            match_over_q   <= 1'b0;
            play_enable_q  <= 1'b0;
            reset_round_q  <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            digit_q        <= digit_d;
            timer_q        <= timer_d;
            human_score_q  <= human_score_d;
            comp_score_q   <= comp_score_d;
            round_winner_q <= round_winner_d;
            match_winner_q <= match_winner_d;
            match_over_q   <= match_over_d;
            play_enable_q  <= play_enable_d;
            reset_round_q  <= reset_round_d;
        end
    end

    assign phase       = phase_q;
    assign digit       = digit_q;
    assign humanScore  = human_score_q;
    assign compScore   = comp_score_q;
    assign roundWinner = round_winner_q;
    assign matchWinner = match_winner_q;
    assign matchOver   = match_over_q;
    assign playEnable  = play_enable_q;
    assign resetRound  = reset_round_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed testbench for match_sequencer with default parameters
// (WIN_TARGET=3, COUNT_FROM=3, COUNT_TICKS=4, HOLD_TICKS=8).
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       humanWin = 1'b0;
    logic       compWin = 1'b0;
    logic       playEnable;
    logic       resetRound;
    logic [2:0] phase;
    logic [2:0] digit;
    logic [2:0] humanScore;
    logic [2:0] compScore;
    logic [1:0] roundWinner;
    logic       matchOver;
    logic       matchWinner;

    int n_tests = 0;
    int n_fail  = 0;

    match_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .humanWin   (humanWin),
        .compWin    (compWin),
        .playEnable (playEnable),
        .resetRound (resetRound),
        .phase      (phase),
        .digit      (digit),
        .humanScore (humanScore),
        .compScore  (compScore),
        .roundWinner(roundWinner),
        .matchOver  (matchOver),
        .matchWinner(matchWinner)
    );

    always #5 clk = ~clk;

    // Outputs packed as {phase, digit, resetRound, playEnable, humanScore,
    // compScore, roundWinner, matchOver, matchWinner}.
    function automatic logic [17:0] ev(int ph, int dg, int rr, int pe, int hs, int cs,
                                       int rw, int mo, int mw);
        return {3'(ph), 3'(dg), 1'(rr), 1'(pe), 3'(hs), 3'(cs), 2'(rw), 1'(mo), 1'(mw)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [17:0] expv);
        logic [17:0] obs;
        obs = {phase, digit, resetRound, playEnable, humanScore, compScore,
               roundWinner, matchOver, matchWinner};
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, expv);
        end
    endtask

    // Checks n countdown cycles starting at the entry cycle; start and win
    // pulses are injected mid-countdown and must have no effect.
    task automatic countdown(string tag, int hs, int cs, int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_cd%0d", tag, i),
                ev(1, 3 - i / 4, (i == 0) ? 1 : 0, 0, hs, cs, 0, 0, 0));
            start    = (i == 5);
            compWin  = (i == 6);
            humanWin = (i == 7);
            step();
        end
        start = 0; compWin = 0; humanWin = 0;
        if (n == 12) chk($sformatf("%s_play", tag), ev(2, 0, 0, 1, hs, cs, 0, 0, 0));
    endtask

    // HOLD cycles j0..7 (entry cycle j=0 is checked by the caller).
    task automatic hold_tail(string tag, int j0, int hs, int cs, int rw);
        for (int j = j0; j < 8; j++) begin
            start   = (j == 4);
            compWin = (j == 5);
            step();
            chk($sformatf("%s_hold%0d", tag, j), ev(3, 0, 0, 0, hs, cs, rw, 0, 0));
        end
        start = 0; compWin = 0;
    endtask

    initial begin
        step();
        step();
        reset = 0;
        chk("reset_state", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        humanWin = 1;
        step();
        humanWin = 0;
        chk("idle_ignores_win", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Start-to-play: entry cycle, 12 countdown cycles, then PLAY.
        start = 1; step(); start = 0;
        countdown("r0", 0, 0, 12);
        start = 1; step(); start = 0;
        chk("play_ignores_start", ev(2, 0, 0, 1, 0, 0, 0, 0, 0));

        // Human win held three cycles credits once.
        humanWin = 1; step();
        chk("hw_hold0", ev(3, 0, 0, 0, 1, 0, 1, 0, 0));
        step(); chk("hw_hold1", ev(3, 0, 0, 0, 1, 0, 1, 0, 0));
        step(); humanWin = 0;
        chk("hw_hold2", ev(3, 0, 0, 0, 1, 0, 1, 0, 0));
        hold_tail("hw", 3, 1, 0, 1);
        step();
        countdown("r1", 1, 0, 12);

        // Tie: no score change, round replayed.
        humanWin = 1; compWin = 1; step(); humanWin = 0; compWin = 0;
        chk("tie_hold0", ev(3, 0, 0, 0, 1, 0, 3, 0, 0));
        hold_tail("tie", 1, 1, 0, 3);
        step();
        countdown("r2", 1, 0, 12);

        // Computer wins three rounds.
        compWin = 1; step(); compWin = 0;
        chk("cw1_hold0", ev(3, 0, 0, 0, 1, 1, 2, 0, 0));
        hold_tail("cw1", 1, 1, 1, 2);
        step();
        countdown("r3", 1, 1, 12);
        compWin = 1; step(); compWin = 0;
        chk("cw2_hold0", ev(3, 0, 0, 0, 1, 2, 2, 0, 0));
        hold_tail("cw2", 1, 1, 2, 2);
        step();
        countdown("r4", 1, 2, 12);
        compWin = 1; step(); compWin = 0;
        chk("over_entry", ev(4, 0, 0, 0, 1, 3, 2, 1, 1));
        compWin = 1; step(); compWin = 0;
        chk("over_cw_frozen", ev(4, 0, 0, 0, 1, 3, 2, 1, 1));
        humanWin = 1; step(); humanWin = 0;
        chk("over_hw_frozen", ev(4, 0, 0, 0, 1, 3, 2, 1, 1));

        // Restart from OVER, then reset mid-countdown with start and win.
        start = 1; step(); start = 0;
        countdown("r5", 0, 0, 5);
        reset = 1; start = 1; humanWin = 1; step();
        reset = 0; start = 0; humanWin = 0;
        chk("rst_countdown", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk("rst_countdown_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset in PLAY with a simultaneous win.
        start = 1; step(); start = 0;
        countdown("r6", 0, 0, 12);
        reset = 1; compWin = 1; step(); reset = 0; compWin = 0;
        chk("rst_play", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk("rst_play_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Build scores 2/1, then reset in HOLD with a simultaneous start.
        start = 1; step(); start = 0;
        countdown("r7", 0, 0, 12);
        humanWin = 1; step(); humanWin = 0;
        chk("h1_hold0", ev(3, 0, 0, 0, 1, 0, 1, 0, 0));
        hold_tail("h1", 1, 1, 0, 1);
        step();
        countdown("r8", 1, 0, 12);
        humanWin = 1; step(); humanWin = 0;
        chk("h2_hold0", ev(3, 0, 0, 0, 2, 0, 1, 0, 0));
        hold_tail("h2", 1, 2, 0, 1);
        step();
        countdown("r9", 2, 0, 12);
        compWin = 1; step(); compWin = 0;
        chk("c1_hold0", ev(3, 0, 0, 0, 2, 1, 2, 0, 0));
        step();
        chk("c1_hold1", ev(3, 0, 0, 0, 2, 1, 2, 0, 0));
        reset = 1; start = 1; step(); reset = 0; start = 0;
        chk("rst_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk("rst_hold_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
